// File: rtl/pe_ctx_sequencer.sv
// Context store and sequencer for one CGRA PE: streams a program in, then replays it N times.
// Defining PE_CTX_READBACK_EN adds a registered debug read port (rb_addr/rb_data).
module pe_ctx_sequencer #(
  parameter int INST_W = 48,
  parameter int DEPTH  = 32,
  parameter int ITER_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INST_W-1:0] cfg_inst,
  input  logic              cfg_last,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              stall,
  input  logic              abort,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [AW-1:0]     ctx_idx,
  output logic [AW:0]       ctx_len,
  output logic              busy,
  output logic              done,
`ifdef PE_CTX_READBACK_EN
  input  logic [AW-1:0]     rb_addr,
  output logic [INST_W-1:0] rb_data,
`endif
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       ctx_idx_q, ctx_idx_d;
  logic [AW:0]         ctx_len_q, ctx_len_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]   iter_max_q, iter_max_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                err_q, err_d;

  logic [INST_W-1:0]   ctx_mem [DEPTH];

  logic cfg_fire, wr_last, rd_last, iter_last;

  // start wins over a simultaneous config word so the run sees a stable program
  assign cfg_ready = (state_q == S_IDLE) && !start;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign wr_last   = cfg_last || (wr_ptr_q == AW'(DEPTH-1));
  assign rd_last   = ({1'b0, rd_ptr_q} == (ctx_len_q - (AW+1)'(1)));
  assign iter_last = (iter_cnt_q == (iter_max_q - ITER_W'(1)));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ctx_idx_d    = ctx_idx_q;
    ctx_len_d    = ctx_len_q;
    iter_cnt_d   = iter_cnt_q;
    iter_max_d   = iter_max_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          if (wr_last) begin
            ctx_len_d = {1'b0, wr_ptr_q} + (AW+1)'(1);
            wr_ptr_d  = '0;
          end else begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
          end
        end
        if (start) begin
          if (ctx_len_q != '0) begin
            iter_max_d = (iter_num == '0) ? ITER_W'(1) : iter_num;
            rd_ptr_d   = '0;
            iter_cnt_d = '0;
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
        end else if (!stall) begin
          inst_d       = ctx_mem[rd_ptr_q];
          ctx_idx_d    = rd_ptr_q;
          inst_valid_d = 1'b1;
          if (rd_last) begin
            rd_ptr_d   = '0;
            iter_cnt_d = iter_cnt_q + ITER_W'(1);
            if (iter_last) state_d = S_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        // final instruction is on the wire this cycle; retire it unless frozen
        if (abort || !stall) begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ctx_idx_q    <= '0;
      ctx_len_q    <= '0;
      iter_cnt_q   <= '0;
      iter_max_q   <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ctx_idx_q    <= ctx_idx_d;
      ctx_len_q    <= ctx_len_d;
      iter_cnt_q   <= iter_cnt_d;
      iter_max_q   <= iter_max_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
    end
  end

  // storage is deliberately not reset; ctx_len=0 fences stale contents
  always_ff @(posedge clk) begin
    if (cfg_fire) ctx_mem[wr_ptr_q] <= cfg_inst;
  end

`ifdef PE_CTX_READBACK_EN
  logic [INST_W-1:0] rb_data_q;
  always_ff @(posedge clk) begin
    if (rst) rb_data_q <= '0;
    else     rb_data_q <= ctx_mem[rb_addr];
  end
  assign rb_data = rb_data_q;
`endif

  assign inst_out   = inst_q;
  assign inst_valid = inst_valid_q;
  assign ctx_idx    = ctx_idx_q;
  assign ctx_len    = ctx_len_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Scoreboard bench for pe_ctx_sequencer: expected instruction stream queued at start,
// popped by a negedge monitor; scenario tasks check control/status inline.
module tb_pe_ctx_sequencer;
  localparam int INST_W = 48;
  localparam int DEPTH  = 32;
  localparam int ITER_W = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_last;
  logic [INST_W-1:0] cfg_inst;
  logic              start, stall, abort;
  logic [ITER_W-1:0] iter_num;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid, busy, done, err;
  logic [AW-1:0]     ctx_idx;
  logic [AW:0]       ctx_len;
`ifdef PE_CTX_READBACK_EN
  logic [AW-1:0]     rb_addr;
  logic [INST_W-1:0] rb_data;
`endif

  pe_ctx_sequencer #(.INST_W(INST_W), .DEPTH(DEPTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_inst(cfg_inst), .cfg_last(cfg_last),
    .start(start), .iter_num(iter_num), .stall(stall), .abort(abort),
    .inst_out(inst_out), .inst_valid(inst_valid), .ctx_idx(ctx_idx), .ctx_len(ctx_len),
    .busy(busy), .done(done),
`ifdef PE_CTX_READBACK_EN
    .rb_addr(rb_addr), .rb_data(rb_data),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [AW-1:0]     idx;
    logic              last;
  } exp_t;

  int                n_vec = 0;
  int                n_err = 0;
  exp_t              sb_q[$];
  exp_t              mon_e;
  logic [INST_W-1:0] prog [DEPTH];

  // every live instruction must match the head of the scoreboard; done only on the last one
  always @(negedge clk) begin
    n_vec++;
    if (inst_valid) begin
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: inst_valid=1 inst=%h idx=%0d, required no output", inst_out, ctx_idx);
      end else begin
        mon_e = sb_q.pop_front();
        if (inst_out !== mon_e.inst || ctx_idx !== mon_e.idx || done !== mon_e.last) begin
          n_err++;
          $display("FAIL stream: got inst=%h idx=%0d done=%b, required inst=%h idx=%0d done=%b",
                   inst_out, ctx_idx, done, mon_e.inst, mon_e.idx, mon_e.last);
        end
      end
    end else if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_without_valid: done=%b, required 0", done);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_inst = '0;
    start = 1'b0; stall = 1'b0; abort = 1'b0; iter_num = '0;
`ifdef PE_CTX_READBACK_EN
    rb_addr = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic load_word(input logic [INST_W-1:0] w, input logic last);
    cfg_inst = w; cfg_last = last; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic do_start(input int iters);
    iter_num = ITER_W'(iters); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run(input int len, input int iters);
    exp_t e;
    for (int it = 0; it < iters; it++)
      for (int i = 0; i < len; i++) begin
        e.inst = prog[i]; e.idx = AW'(i); e.last = (it == iters-1) && (i == len-1);
        sb_q.push_back(e);
      end
  endtask

  task automatic drain(input int budget, output bit ok);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    ok = (sb_q.size() == 0);
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_vec++; if (inst_out !== '0)    begin n_err++; $display("FAIL reset_inst_out: got %h, required 0", inst_out); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
    n_vec++; if (ctx_idx !== '0)     begin n_err++; $display("FAIL reset_ctx_idx: got %0d, required 0", ctx_idx); end
    n_vec++; if (ctx_len !== '0)     begin n_err++; $display("FAIL reset_ctx_len: got %0d, required 0", ctx_len); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      begin n_err++; $display("FAIL reset_status: got busy=%b done=%b err=%b, required 0 0 0", busy, done, err); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      prog[i] = {8'hA0, 40'(i)};
      load_word(prog[i], i == 3);
    end
    n_vec++; if (ctx_len !== 6'd4) begin n_err++; $display("FAIL basic_ctx_len: got %0d, required 4", ctx_len); end
    push_run(4, 3);
    do_start(3);
    n_vec++; if (busy !== 1'b1 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL basic_latency_t1: got busy=%b valid=%b, required 1 0", busy, inst_valid); end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_run: cycle %0d got valid=%b, required 1", i, inst_valid); end
    end
    tick();
    n_vec++; if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL basic_after: got valid=%b busy=%b done=%b, required 0 0 0", inst_valid, busy, done); end
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL basic_count: %0d words left, required 0", sb_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = {8'hB0, 40'(i)};
      load_word(prog[i], 1'b0);
    end
    n_vec++; if (ctx_len !== 6'd32) begin n_err++; $display("FAIL wrap_ctx_len: got %0d, required 32", ctx_len); end
    push_run(DEPTH, 1);
    do_start(1);
    drain(80, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_run_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    prog[0] = 48'hC0C0_0000_0000;
    load_word(prog[0], 1'b0);
    n_vec++; if (ctx_len !== 6'd32) begin n_err++; $display("FAIL wrap_midload_len: got %0d, required 32", ctx_len); end
    prog[1] = 48'hC0C0_0000_0001;
    load_word(prog[1], 1'b1);
    n_vec++; if (ctx_len !== 6'd2) begin n_err++; $display("FAIL wrap_short_len: got %0d, required 2", ctx_len); end
    push_run(2, 1);
    do_start(0);
    drain(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_iter0_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    n_vec++; if (inst_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL wrap_iter0_end: got valid=%b busy=%b, required 0 0", inst_valid, busy); end
  endtask

  task automatic test_err();
    bit ok;
    do_reset();
    do_start(1);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b, required 1", err); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (busy !== 1'b0 || inst_valid !== 1'b0)
        begin n_err++; $display("FAIL err_idle: got busy=%b valid=%b, required 0 0", busy, inst_valid); end
      tick();
    end
    prog[0] = 48'hE000_0000_0000; load_word(prog[0], 1'b0);
    prog[1] = 48'hE000_0000_0001; load_word(prog[1], 1'b1);
    push_run(2, 1);
    do_start(1);
    drain(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL err_rerun_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    n_vec++; if (err !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL err_sticky: got err=%b busy=%b, required 1 0", err, busy); end
  endtask

  task automatic test_stall();
    bit ok;
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      prog[i] = {8'hF0, 40'(i)};
      load_word(prog[i], i == 2);
    end
    // stall lands on the first ctx_idx=1 cycle: that word shows 1+5 times
    e = '{inst: prog[0], idx: AW'(0), last: 1'b0}; sb_q.push_back(e);
    e = '{inst: prog[1], idx: AW'(1), last: 1'b0};
    for (int i = 0; i < 6; i++) sb_q.push_back(e);
    e = '{inst: prog[2], idx: AW'(2), last: 1'b0}; sb_q.push_back(e);
    e = '{inst: prog[0], idx: AW'(0), last: 1'b0}; sb_q.push_back(e);
    e = '{inst: prog[1], idx: AW'(1), last: 1'b0}; sb_q.push_back(e);
    e = '{inst: prog[2], idx: AW'(2), last: 1'b1}; sb_q.push_back(e);
    do_start(2);
    for (int i = 0; i < 20 && !(inst_valid === 1'b1 && ctx_idx === AW'(1)); i++) tick();
    n_vec++; if (!(inst_valid === 1'b1 && ctx_idx === AW'(1)))
      begin n_err++; $display("FAIL stall_reach_idx1: got valid=%b idx=%0d, required 1 1", inst_valid, ctx_idx); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (inst_out !== prog[1] || ctx_idx !== AW'(1) || inst_valid !== 1'b1)
        begin n_err++; $display("FAIL stall_hold: got inst=%h idx=%0d valid=%b, required %h 1 1", inst_out, ctx_idx, inst_valid, prog[1]); end
    end
    stall = 1'b0;
    drain(30, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_end_busy: got %b, required 0", busy); end
  endtask

  task automatic test_abort();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      prog[i] = {8'hD0, 40'(i)};
      load_word(prog[i], i == 3);
    end
    push_run(4, 2);
    do_start(2);
    for (int i = 0; i < 20 && sb_q.size() > 4; i++) tick();
    n_vec++; if (sb_q.size() != 4 || inst_valid !== 1'b1)
      begin n_err++; $display("FAIL abort_reach4: got left=%0d valid=%b, required 4 1", sb_q.size(), inst_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb_q.delete();
    n_vec++; if (inst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL abort_stop: got valid=%b busy=%b done=%b, required 0 0 0", inst_valid, busy, done); end
    tick(); tick();
    n_vec++; if (ctx_len !== 6'd4) begin n_err++; $display("FAIL abort_ctx_len: got %0d, required 4", ctx_len); end
    push_run(4, 2);
    do_start(2);
    drain(30, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL abort_rerun_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_rerun_end: busy=%b, required 0", busy); end
  endtask

  task automatic test_start_cfg_same();
    bit ok;
    push_run(4, 1);
    cfg_inst = 48'hDEAD_BEEF_0000; cfg_last = 1'b1; cfg_valid = 1'b1;
    iter_num = ITER_W'(1); start = 1'b1;
    #1;
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL same_cfg_ready: got %b, required 0", cfg_ready); end
    tick();
    start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    drain(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL same_run_timeout: %0d words left, required 0", sb_q.size()); end
    tick();
    n_vec++; if (ctx_len !== 6'd4) begin n_err++; $display("FAIL same_no_write: ctx_len=%0d, required 4", ctx_len); end
`ifdef PE_CTX_READBACK_EN
    rb_addr = AW'(2);
    tick();
    n_vec++; if (rb_data !== prog[2]) begin n_err++; $display("FAIL readback: got %h, required %h", rb_data, prog[2]); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_err();
    test_stall();
    test_abort();
    test_start_cfg_same();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
